// File: rtl/tt_sweep_pkg.sv
// +----------------------------------------------------------------------------+
// | tt_sweep_pkg : shared types and constants for the truth-table sweeper       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned TT_SETTLE_MIN = 1;

endpackage

`default_nettype wire

// File: rtl/tt_settle_timer.sv
// +----------------------------------------------------------------------------+
// | tt_settle_timer : SETTLE-cycle down-counter with load and expire            |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tt_settle_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = LOAD_VAL;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/tt_sweep.sv
// +----------------------------------------------------------------------------+
// | tt_sweep : drives every input vector into a gate and checks its response    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tt_sweep
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [2**N_IN-1:0]   i_expected,
  output logic [N_IN-1:0]      o_stim,
  input  logic                 i_resp,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [N_IN:0]        o_fail_cnt,
  output logic [N_IN-1:0]      o_fail_idx,
  output logic [2**N_IN-1:0]   o_observed
);

  localparam int unsigned       N_VEC      = 2**N_IN;
  localparam int unsigned       SETTLE_EFF = (SETTLE < TT_SETTLE_MIN) ? TT_SETTLE_MIN : SETTLE;
  localparam logic [N_IN-1:0]   IDX_LAST   = N_IN'(N_VEC - 1);

  state_t              state_q, state_d;
  logic [N_IN-1:0]     idx_q, idx_d;
  logic [N_VEC-1:0]    exp_q, exp_d;
  logic [N_VEC-1:0]    obs_q, obs_d;
  logic [N_IN:0]       fail_cnt_q, fail_cnt_d;
  logic [N_IN-1:0]     fail_idx_q, fail_idx_d;
  logic                pass_q, pass_d;

  logic w_timer_load;
  logic w_timer_en;
  logic w_timer_expire;

  tt_settle_timer #(
    .SETTLE (SETTLE_EFF)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_timer_load),
    .i_en     (w_timer_en),
    .o_expire (w_timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    exp_d        = exp_q;
    obs_d        = obs_q;
    fail_cnt_d   = fail_cnt_q;
    fail_idx_d   = fail_idx_q;
    pass_d       = pass_q;
    w_timer_load = 1'b0;
    w_timer_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          exp_d        = i_expected;
          obs_d        = '0;
          fail_cnt_d   = '0;
          fail_idx_d   = '0;
          pass_d       = 1'b0;
          idx_d        = '0;
          w_timer_load = 1'b1;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_timer_expire) begin
          state_d = ST_SAMPLE;
        end else begin
          w_timer_en = 1'b1;
        end
      end
      ST_SAMPLE: begin
        obs_d[idx_q] = i_resp;
        if (i_resp != exp_q[idx_q]) begin
          fail_cnt_d = fail_cnt_q + (N_IN+1)'(1);
          // Only the first mismatch records its index
          if (fail_cnt_q == '0) begin
            fail_idx_d = idx_q;
          end
        end
        if (idx_q == IDX_LAST) begin
          pass_d  = (fail_cnt_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d        = idx_q + N_IN'(1);
          w_timer_load = 1'b1;
          state_d      = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      exp_q      <= '0;
      obs_q      <= '0;
      fail_cnt_q <= '0;
      fail_idx_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      exp_q      <= exp_d;
      obs_q      <= obs_d;
      fail_cnt_q <= fail_cnt_d;
      fail_idx_q <= fail_idx_d;
      pass_q     <= pass_d;
    end
  end

  assign o_stim     = (state_q == ST_IDLE) ? '0 : idx_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = (state_q == ST_DONE);
  assign o_pass     = pass_q;
  assign o_fail_cnt = fail_cnt_q;
  assign o_fail_idx = fail_idx_q;
  assign o_observed = obs_q;

endmodule

`default_nettype wire

// File: tb/tb_tt_sweep.sv
// +----------------------------------------------------------------------------+
// | tb_tt_sweep : directed scoreboard bench for tt_sweep driving an a->b gate   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tt_sweep;

  typedef struct packed {
    logic       pass;
    logic [2:0] cnt;
    logic [1:0] idx;
    logic [3:0] obs;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]      start;
  logic [1:0][3:0] expd;

  wire [1:0][1:0] stim;
  wire [1:0]      resp;
  wire [1:0]      busy;
  wire [1:0]      done;
  wire [1:0]      pass;
  wire [1:0][2:0] fcnt;
  wire [1:0][1:0] fidx;
  wire [1:0][3:0] obs;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t sb_q[$];

  always #5 clk = ~clk;

  // Gate under test (my_module): o_c = ~i_a | i_b, i_a = stim[0], i_b = stim[1]
  assign resp[0] = ~stim[0][0] | stim[0][1];
  assign resp[1] = ~stim[1][0] | stim[1][1];

  tt_sweep #(.N_IN(2), .SETTLE(1)) u_dut_s1 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_expected(expd[0]),
    .o_stim(stim[0]), .i_resp(resp[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_pass(pass[0]), .o_fail_cnt(fcnt[0]), .o_fail_idx(fidx[0]), .o_observed(obs[0])
  );

  tt_sweep #(.N_IN(2), .SETTLE(3)) u_dut_s3 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_expected(expd[1]),
    .o_stim(stim[1]), .i_resp(resp[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_pass(pass[1]), .o_fail_cnt(fcnt[1]), .o_fail_idx(fidx[1]), .o_observed(obs[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic res_t model(input logic [3:0] expv);
    res_t r;
    logic a, b;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      a = k[0];
      b = k[1];
      r.obs[k] = ~a | b;
      if (r.obs[k] != expv[k]) begin
        if (r.cnt == 3'd0) r.idx = 2'(k);
        r.cnt = r.cnt + 3'd1;
      end
    end
    r.pass = (r.cnt == 3'd0);
    return r;
  endfunction

  task automatic check_zero(input int u, input string pfx);
    check({pfx, "_stim"}, 32'(stim[u]), 0);
    check({pfx, "_busy"}, 32'(busy[u]), 0);
    check({pfx, "_done"}, 32'(done[u]), 0);
    check({pfx, "_pass"}, 32'(pass[u]), 0);
    check({pfx, "_fcnt"}, 32'(fcnt[u]), 0);
    check({pfx, "_fidx"}, 32'(fidx[u]), 0);
    check({pfx, "_obs"},  32'(obs[u]),  0);
  endtask

  // One sweep on instance u; optionally re-pulse start and alter i_expected mid-sweep
  task automatic sweep(input int u, input logic [3:0] expv, input int settle, input bit disturb);
    res_t want;
    bit   seen;
    int   edges;
    int   lat;
    seen  = 1'b0;
    edges = 0;
    lat   = 4 * (settle + 1) + 1;
    sb_q.push_back(model(expv));
    expd[u]  = expv;
    start[u] = 1'b1;
    for (int j = 1; j <= 40 && !seen; j++) begin
      @(posedge clk); #1;
      if (j == 1) start[u] = 1'b0;
      if (disturb && j == 2) start[u] = 1'b1;
      if (disturb && j == 3) begin
        start[u] = 1'b0;
        expd[u]  = 4'b0000;
      end
      if (done[u]) begin
        seen  = 1'b1;
        edges = j;
      end else if (j < lat) begin
        check($sformatf("stim_u%0d_c%0d", u, j), 32'(stim[u]), 32'((j - 1) / (settle + 1)));
        check($sformatf("busy_u%0d_c%0d", u, j), 32'(busy[u]), 1);
      end
    end
    check("done_seen", 32'(seen), 1);
    want = sb_q.pop_front();
    if (seen) begin
      check("latency",  32'(edges),   32'(lat));
      check("busy_done", 32'(busy[u]), 1);
      check("pass",     32'(pass[u]), 32'(want.pass));
      check("fail_cnt", 32'(fcnt[u]), 32'(want.cnt));
      check("fail_idx", 32'(fidx[u]), 32'(want.idx));
      check("observed", 32'(obs[u]),  32'(want.obs));
      for (int j = 0; j < 4; j++) begin
        @(posedge clk); #1;
        check("post_done", 32'(done[u]), 0);
        check("post_busy", 32'(busy[u]), 0);
        check("post_stim", 32'(stim[u]), 0);
        check("hold_pass", 32'(pass[u]), 32'(want.pass));
        check("hold_obs",  32'(obs[u]),  32'(want.obs));
      end
    end
  endtask

  initial begin
    bit any_done;
    rst   = 1'b1;
    start = '0;
    expd  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero(0, "rst_s1");
    check_zero(1, "rst_s3");
    rst = 1'b0;

    sweep(0, 4'b1101, 1, 1'b0);
    sweep(0, 4'b1111, 1, 1'b0);
    sweep(0, 4'b0010, 1, 1'b0);
    sweep(0, 4'b1101, 1, 1'b1);

    // Reset four cycles into a sweep aborts it silently
    expd[0]  = 4'b1101;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("busy_before_rst", 32'(busy[0]), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero(0, "midrst");
    any_done = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      if (done[0]) any_done = 1'b1;
    end
    check("no_done_after_rst", 32'(any_done), 0);

    sweep(0, 4'b1101, 1, 1'b0);
    sweep(1, 4'b1101, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tt_sweep.md
# tt_sweep

Sequential truth-table sweeper that drives every input combination into a small combinational gate under test and checks each response against an expected truth table. Sits directly upstream of a gate such as `my_module`, feeding its inputs, and also consumes its output. Each sweep is started by a one-cycle pulse and reports pass/fail, the first failing index, the failure count and the captured table. It is the synthesizable, self-checking replacement for hand-written per-vector checks.

## Interface
- `N_IN`, default 2: number of gate inputs; 2**N_IN vectors per sweep.
- `SETTLE`, default 1: cycles each vector is held before sampling; must be ≥1.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_start`  in  1  start a sweep; honoured only in IDLE.
- `i_expected`  in  2**N_IN  expected output, bit k = response to vector k; latched at start.
- `o_stim`  out  N_IN  vector to the gate; bit 0 drives the first gate input (`i_a`), bit 1 the second (`i_b`).
- `i_resp`  in  1  gate output (`o_c`).
- `o_busy`  out  1  high from the cycle after start acceptance through the DONE cycle.
- `o_done`  out  1  one-cycle pulse when a sweep completes.
- `o_pass`  out  1  1 iff the last completed sweep had zero mismatches; held until the next start.
- `o_fail_cnt`  out  N_IN+1  mismatches in the last sweep.
- `o_fail_idx`  out  N_IN  lowest mismatching vector index; 0 if none.
- `o_observed`  out  2**N_IN  captured responses, bit k = response to vector k.

## Operation
- The FSM has four states: IDLE, SETTLE, SAMPLE, DONE.
- **IDLE:** `o_stim` = 0 and `o_busy` = 0. On `i_start` = 1:
  - latch `i_expected` into `exp_q`;
  - clear `o_observed`, `o_fail_cnt`, `o_fail_idx` and `o_pass`;
  - set idx = 0 and the settle counter to 0;
  - go to SETTLE.
- **SETTLE:** `o_stim` = idx. Increment the settle counter. Go to SAMPLE when the counter reaches SETTLE-1, so the state lasts exactly SETTLE cycles.
- **SAMPLE:** `o_stim` still equals idx. At the closing edge:
  - write `o_observed[idx]` = `i_resp`;
  - if `i_resp` != `exp_q[idx]`, increment `o_fail_cnt`; if this is the first mismatch, set `o_fail_idx` = idx;
  - if idx = 2**N_IN-1, go to DONE; otherwise increment idx, reset the counter and go to SETTLE.
- **DONE:** lasts one cycle. `o_done` = 1 and `o_pass` = (`o_fail_cnt` == 0). Go to IDLE.
- **Start while busy:** `i_start` outside IDLE is ignored. `i_expected` changes after acceptance have no effect.
- **Back-to-back sweeps:** a start in the IDLE cycle right after DONE is accepted.
- **Width rule:** idx is N_IN bits; increment only when idx < 2**N_IN-1, so it never wraps inside a sweep. `o_fail_cnt` at N_IN+1 bits holds the maximum 2**N_IN.

## Timing
- **Reset values:** state IDLE; all outputs 0 (`o_stim`, `o_busy`, `o_done`, `o_pass`, `o_fail_cnt`, `o_fail_idx`, `o_observed`).
- **Reset mid-sweep:** all of the above apply at the next edge; no `o_done` pulse for the aborted sweep.
- **Start to done:** with `i_start` sampled high at edge k, `o_done` is high in cycle k + 2**N_IN·(SETTLE+1) + 1. For N_IN=2, SETTLE=1 this is 9 cycles.
- **Vector hold time:** each vector is held on `o_stim` for SETTLE+1 cycles, so the gate has at least SETTLE cycles to settle before sampling.
- **Result timing:** `o_pass`, `o_fail_cnt`, `o_fail_idx` and `o_observed` are final in the DONE cycle and stable until the next accepted start.

## Structure
- Package `tt_sweep_pkg` holds the `state_t` enum (IDLE, SETTLE, SAMPLE, DONE) and the `TT_SETTLE_MIN` = 1 constant.
- Sub-module `tt_settle_timer`: a SETTLE-cycle down-counter with `load` and `expire`. This is the only natural split.
- The FSM, idx register and result registers stay in `tt_sweep`.

## Test plan
All scenarios use `tt_sweep` wired to `my_module` (`o_stim[0]`→`i_a`, `o_stim[1]`→`i_b`, `o_c`→`i_resp`), with N_IN=2.
1. SETTLE=1, start with `i_expected`=4'b1101 → `o_done` 9 cycles later; `o_pass`=1, `o_fail_cnt`=0, `o_fail_idx`=0, `o_observed`=4'b1101; `o_stim` steps 0,1,2,3 for 2 cycles each.
2. `i_expected`=4'b1111 → `o_pass`=0, `o_fail_cnt`=1, `o_fail_idx`=1, `o_observed`=4'b1101.
3. `i_expected`=4'b0010 → `o_fail_cnt`=4, `o_fail_idx`=0, `o_pass`=0.
4. Pulse `i_start` again and change `i_expected` to 4'b0000 three cycles into a 4'b1101 sweep → single `o_done`; results as scenario 1.
5. Assert `i_rst` 4 cycles after start → next cycle all outputs 0 and no `o_done`; a fresh start then completes as scenario 1.
6. SETTLE=3, `i_expected`=4'b1101 → `o_done` 17 cycles after start; each `o_stim` value is held 4 cycles; `o_pass`=1.
